// File: rtl/kl_ucb_bisect_engine.sv
// ============================================================================
// Module   : kl_ucb_bisect_engine
// Brief    : Fixed-point KL-UCB upper-bound search by bisection against an
//            external KL-divergence comparator, with valid/ready on both ends.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kl_ucb_bisect_engine #(
  parameter int FRAC_W = 16,
  parameter int N_ITER = 16,
  parameter int EPS    = 0
) (
  input  logic            s_aclk,
  input  logic            s_aresetn,
  input  logic [FRAC_W:0] s_p_tdata,
  input  logic [FRAC_W:0] s_d_tdata,
  input  logic            s_tvalid,
  output logic            s_tready,
  output logic            kl_req_valid,
  input  logic            kl_req_ready,
  output logic [FRAC_W:0] kl_p,
  output logic [FRAC_W:0] kl_q,
  output logic [FRAC_W:0] kl_d,
  input  logic            kl_rsp_valid,
  input  logic            kl_rsp_le,
  output logic [FRAC_W:0] m_q_tdata,
  output logic [7:0]      m_iter,
  output logic            m_tvalid,
  input  logic            m_tready
);

  localparam int W = FRAC_W + 1;
  localparam logic [W-1:0]   ONE      = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [2*W-1:0] ONE_WIDE = {{W{1'b0}}, ONE};
  localparam logic [W-1:0]   EPS_W    = W'(EPS);
  localparam logic [8:0]     N_ITER_X = 9'(N_ITER);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] lm_q, lm_d;
  logic [W-1:0] um_q, um_d;
  logic [7:0]   iter_q, iter_d;

  logic [W-1:0]   w_dh;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_sum;
  logic [W-1:0]   w_um_init;
  logic [W-1:0]   w_mid;
  logic [W-1:0]   w_lm_new;
  logic [W-1:0]   w_um_new;
  logic [8:0]     w_iter_inc;

  // Initial upper bound: p + (d/2)^2, saturated at ONE; the wide sum cannot wrap.
  assign w_dh      = d_q >> 1;
  assign w_prod    = {{W{1'b0}}, w_dh} * {{W{1'b0}}, w_dh};
  assign w_sum     = {{W{1'b0}}, p_q} + (w_prod >> FRAC_W);
  assign w_um_init = (w_sum > ONE_WIDE) ? ONE : w_sum[W-1:0];

  // floor((um + lm) / 2) without a carry bit
  assign w_mid      = (um_q >> 1) + (lm_q >> 1) + W'(um_q[0] & lm_q[0]);
  assign w_lm_new   = kl_rsp_le ? w_mid : lm_q;
  assign w_um_new   = kl_rsp_le ? um_q  : w_mid;
  assign w_iter_inc = {1'b0, iter_q} + 9'd1;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      d_q     <= '0;
      lm_q    <= '0;
      um_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      lm_q    <= lm_d;
      um_q    <= um_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    d_d          = d_q;
    lm_d         = lm_q;
    um_d         = um_q;
    iter_d       = iter_q;
    s_tready     = 1'b0;
    kl_req_valid = 1'b0;
    kl_p         = '0;
    kl_q         = '0;
    kl_d         = '0;
    m_q_tdata    = '0;
    m_iter       = '0;
    m_tvalid     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          p_d     = (s_p_tdata > ONE) ? ONE : s_p_tdata;
          d_d     = s_d_tdata;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        lm_d   = p_q;
        um_d   = w_um_init;
        iter_d = '0;
        if (((w_um_init - p_q) <= EPS_W) || (N_ITER == 0)) state_d = ST_DONE;
        else                                                state_d = ST_REQ;
      end
      ST_REQ: begin
        kl_req_valid = 1'b1;
        kl_p         = p_q;
        kl_q         = w_mid;
        kl_d         = d_q;
        if (kl_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (kl_rsp_valid) begin
          lm_d   = w_lm_new;
          um_d   = w_um_new;
          iter_d = iter_q + 8'd1;
          if ((w_iter_inc == N_ITER_X) || ((w_um_new - w_lm_new) <= EPS_W)) state_d = ST_DONE;
          else                                                             state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        m_tvalid  = 1'b1;
        m_q_tdata = um_q;
        m_iter    = iter_q;
        if (m_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_kl_ucb_bisect_engine.sv
// ============================================================================
// Module   : tb_kl_ucb_bisect_engine
// Brief    : Directed self-checking bench with a behavioural KL comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kl_ucb_bisect_engine;

  localparam int W   = 17;
  localparam int ONE = 65536;

  logic         s_aclk;
  logic         s_aresetn;
  logic [W-1:0] s_p_tdata;
  logic [W-1:0] s_d_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         kl_req_valid;
  logic         kl_req_ready;
  logic [W-1:0] kl_p;
  logic [W-1:0] kl_q;
  logic [W-1:0] kl_d;
  logic         kl_rsp_valid;
  logic         kl_rsp_le;
  logic [W-1:0] m_q_tdata;
  logic [7:0]   m_iter;
  logic         m_tvalid;
  logic         m_tready;

  int checks   = 0;
  int failures = 0;

  // Comparator model knobs (main sequence writes, comparator reads) and its counters
  int           req_total  = 0;
  int           resp_given = 0;
  int           resp_limit = 32'h3fff_ffff;
  int           spur_req   = 0;
  int           spur_ack   = 0;
  logic         le_mode    = 1'b1;
  logic         spur_le    = 1'b0;
  logic         chk_ops    = 1'b0;
  logic [W-1:0] exp_p      = '0;
  logic [W-1:0] exp_d      = '0;

  kl_ucb_bisect_engine #(.FRAC_W(16), .N_ITER(16), .EPS(0)) dut (
    .s_aclk       (s_aclk),
    .s_aresetn    (s_aresetn),
    .s_p_tdata    (s_p_tdata),
    .s_d_tdata    (s_d_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .kl_req_valid (kl_req_valid),
    .kl_req_ready (kl_req_ready),
    .kl_p         (kl_p),
    .kl_q         (kl_q),
    .kl_d         (kl_d),
    .kl_rsp_valid (kl_rsp_valid),
    .kl_rsp_le    (kl_rsp_le),
    .m_q_tdata    (m_q_tdata),
    .m_iter       (m_iter),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready)
  );

  initial begin
    s_aclk = 1'b0;
    forever #5 s_aclk = ~s_aclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Zero-wait comparator: answers one cycle after each accepted request.
  initial begin : comparator
    bit fire;
    kl_rsp_valid = 1'b0;
    kl_rsp_le    = 1'b0;
    forever begin
      @(negedge s_aclk);
      fire = kl_req_valid && kl_req_ready;
      if (fire) begin
        req_total++;
        if (chk_ops) begin
          checks++;
          assert (kl_p === exp_p && kl_d === exp_d) else begin
            failures++;
            $error("FAIL kl_operands observed p=%0d d=%0d expected p=%0d d=%0d", kl_p, kl_d, exp_p, exp_d);
          end
        end
      end
      @(posedge s_aclk);
      #1;
      if (fire && resp_given < resp_limit) begin
        kl_rsp_valid = 1'b1;
        kl_rsp_le    = le_mode;
        resp_given++;
      end else if (spur_req != spur_ack) begin
        kl_rsp_valid = 1'b1;
        kl_rsp_le    = spur_le;
        spur_ack     = spur_req;
      end else begin
        kl_rsp_valid = 1'b0;
        kl_rsp_le    = 1'b0;
      end
    end
  end

  task automatic start_job(input int p, input int d);
    @(posedge s_aclk); #1;
    s_p_tdata = W'(p);
    s_d_tdata = W'(d);
    s_tvalid  = 1'b1;
    @(negedge s_aclk);
    check("s_tready_idle", 32'(s_tready), 1);
    @(posedge s_aclk); #1;
    s_tvalid  = 1'b0;
    s_p_tdata = '0;
    s_d_tdata = '0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge s_aclk);
      cyc++;
    end while (!m_tvalid && cyc < 2000);
    check("done_within_budget", 32'(m_tvalid), 1);
  endtask

  task automatic finish_job(input int exp_q, input int exp_iter, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge s_aclk);
      check("hold_m_tvalid", 32'(m_tvalid), 1);
      check("hold_m_q", 32'(m_q_tdata), 32'(exp_q));
      check("hold_m_iter", 32'(m_iter), 32'(exp_iter));
      check("hold_s_tready", 32'(s_tready), 0);
    end
    @(posedge s_aclk); #1;
    m_tready = 1'b1;
    @(posedge s_aclk); #1;
    m_tready = 1'b0;
    @(negedge s_aclk);
    check("post_s_tready", 32'(s_tready), 1);
    check("post_m_tvalid", 32'(m_tvalid), 0);
  endtask

  task automatic run_job(input int p, input int d, input logic le, input int exp_q,
                         input int exp_iter, input int hold);
    int start;
    int cyc;
    exp_p        = W'((p > ONE) ? ONE : p);
    exp_d        = W'(d);
    le_mode      = le;
    chk_ops      = 1'b1;
    kl_req_ready = 1'b1;
    start        = req_total;
    start_job(p, d);
    wait_done(cyc);
    check("latency", 32'(cyc), 32'(2 + 2 * exp_iter));
    check("m_q", 32'(m_q_tdata), 32'(exp_q));
    check("m_iter", 32'(m_iter), 32'(exp_iter));
    check("req_count", 32'(req_total - start), 32'(exp_iter));
    finish_job(exp_q, exp_iter, hold);
  endtask

  initial begin : main
    int start;
    int cyc;
    s_aresetn    = 1'b0;
    s_p_tdata    = '0;
    s_d_tdata    = '0;
    s_tvalid     = 1'b0;
    kl_req_ready = 1'b0;
    m_tready     = 1'b0;
    #2;
    check("rst_s_tready", 32'(s_tready), 1);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_kl_req_valid", 32'(kl_req_valid), 0);
    check("rst_m_q", 32'(m_q_tdata), 0);
    check("rst_m_iter", 32'(m_iter), 0);
    repeat (2) @(posedge s_aclk);
    #1 s_aresetn = 1'b1;

    // Zero budget: empty bracket, no comparator traffic
    run_job(32768, 0, 1'b1, 32768, 0, 0);
    // p above ONE is clamped
    run_job(70000, 0, 1'b1, 65536, 0, 0);
    // Bracket width stalls at 1, runs the full 16 iterations; result held 5 cycles
    run_job(16384, 65536, 1'b1, 32768, 16, 5);
    // Saturated upper bound, early exit on empty bracket
    run_job(58982, 65536, 1'b0, 58982, 13, 0);

    // Request backpressure with a spurious response pulse while in REQ
    exp_p        = W'(16384);
    exp_d        = W'(65536);
    le_mode      = 1'b1;
    kl_req_ready = 1'b0;
    start        = req_total;
    start_job(16384, 65536);
    @(negedge s_aclk);
    for (int k = 0; k < 7; k++) begin
      @(negedge s_aclk);
      check("stall_kl_req_valid", 32'(kl_req_valid), 1);
      check("stall_kl_q", 32'(kl_q), 24576);
      check("stall_no_accept", 32'(req_total - start), 0);
      if (k == 1) begin
        spur_le = 1'b0;
        spur_req++;
      end
    end
    @(posedge s_aclk); #1;
    kl_req_ready = 1'b1;
    wait_done(cyc);
    check("stall_m_q", 32'(m_q_tdata), 32768);
    check("stall_m_iter", 32'(m_iter), 16);
    check("stall_req_count", 32'(req_total - start), 16);
    finish_job(32768, 16, 0);

    // Reset while waiting on the 6th response (iter=5)
    resp_limit = resp_given + 5;
    le_mode    = 1'b1;
    start      = req_total;
    start_job(16384, 65536);
    cyc = 0;
    while ((req_total - start) < 6 && cyc < 500) begin
      @(negedge s_aclk);
      cyc++;
    end
    check("reached_wait_iter5", 32'(req_total - start), 6);
    @(negedge s_aclk);
    check("in_wait_no_req", 32'(kl_req_valid), 0);
    @(posedge s_aclk); #1;
    s_aresetn = 1'b0;
    #1;
    check("arst_s_tready", 32'(s_tready), 1);
    check("arst_kl_req_valid", 32'(kl_req_valid), 0);
    check("arst_kl_q", 32'(kl_q), 0);
    check("arst_m_tvalid", 32'(m_tvalid), 0);
    check("arst_m_q", 32'(m_q_tdata), 0);
    check("arst_m_iter", 32'(m_iter), 0);
    resp_limit = 32'h3fff_ffff;
    spur_le    = 1'b0;
    spur_req++;
    repeat (2) @(posedge s_aclk);
    #1 s_aresetn = 1'b1;
    spur_req++;
    repeat (3) @(negedge s_aclk);
    check("idle_after_spur", 32'(s_tready), 1);
    run_job(16384, 65536, 1'b1, 32768, 16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kl_ucb_bisect_engine.md
Name: kl_ucb_bisect_engine

Overview:
- Parametrised fixed-point successor of the floating-point KL-UCB back-end.
- Accepts empirical mean p and exploration budget d, and forms initial bounds lm = p, um = min(1, p + (d/2)^2).
- Runs up to N_ITER bisection steps against an external KL-divergence comparator through a req/rsp handshake, then returns q = um.
- Adds early termination on bracket width, input/output valid-ready backpressure, and an iteration-count output.

Parameters:
- FRAC_W, 16, fraction bits; data width W = FRAC_W+1, unsigned Q1.FRAC_W, ONE = 1<<FRAC_W.
- N_ITER, 16, maximum bisection iterations (0..255).
- EPS, 0, early-exit threshold on (um - lm) in LSBs.

Ports:
- s_aclk  in  1  clock.
- s_aresetn  in  1  asynchronous active-low reset.
- s_p_tdata  in  W  empirical mean p.
- s_d_tdata  in  W  budget d.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- kl_req_valid  out  1  comparator request valid.
- kl_req_ready  in  1  comparator accepts request.
- kl_p  out  W  p operand.
- kl_q  out  W  candidate mid.
- kl_d  out  W  budget operand.
- kl_rsp_valid  in  1  comparator result valid (1-cycle pulse).
- kl_rsp_le  in  1  1 when KL(p,mid) <= d.
- m_q_tdata  out  W  result q.
- m_iter  out  8  iterations actually performed.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release) puts the FSM in IDLE.
  - All outputs read 0, except s_tready = 1 in IDLE.
  - Internal p, d, lm, um and iter registers are cleared.
- IDLE:
  - s_tready = 1.
  - On s_tvalid & s_tready, register p and d. If p > ONE, clamp p to ONE.
  - Go to INIT.
- INIT (1 cycle):
  - dh = d >> 1.
  - sq = (dh*dh) >> FRAC_W, truncated, with a 2W-bit product.
  - sum = p + sq in W+1 bits; um = (sum > ONE) ? ONE : sum[W-1:0].
  - lm = p; iter = 0.
  - If (um - lm) <= EPS or N_ITER == 0, go to DONE; otherwise go to REQ.
- REQ:
  - kl_req_valid = 1.
  - kl_q = (um + lm) >> 1, computed in W+1 bits. kl_p = p, kl_d = d.
  - All three operands are held stable while kl_req_valid is high.
  - On kl_req_ready, go to WAIT.
- WAIT:
  - On kl_rsp_valid: if kl_rsp_le, lm = mid; else um = mid. Then iter += 1.
  - Next state is DONE if iter+1 == N_ITER or the new (um - lm) <= EPS; otherwise REQ.
- kl_rsp_valid is ignored in every state other than WAIT.
- The comparator response may take any number of cycles; there is no timeout.
- DONE:
  - m_tvalid = 1, m_q_tdata = um, m_iter = iter. All three hold stable until m_tready.
  - On m_tvalid & m_tready, go to IDLE; s_tready is asserted the following cycle.
- Invariant: lm <= mid <= um at all times, and um <= ONE.
- Latency from input handshake to m_tvalid, with a zero-wait comparator (ready high, response one cycle after acceptance): 2 + 2*iterations cycles.
- Reset asserted mid-operation abandons the job immediately. Any in-flight comparator response is dropped.

Test Plan:
- FRAC_W=16, EPS=0: p=32768, d=0 -> sq=0, um=lm, no kl_req_valid, q=32768, m_iter=0, m_tvalid 2 cycles after the input handshake.
- p=16384, d=65536, comparator always le=1:
  - Initial um=32768, lm=16384.
  - Bracket width stalls at 1, so the run ends at m_iter=16 with q=32768.
  - Exactly 16 requests are issued, each with kl_p=16384 and kl_d=65536.
- p=58982, d=65536: sum 75366 saturates, um=65536. Comparator always le=0 -> early exit at m_iter=13 with q=58982.
- Backpressure:
  - kl_req_ready held low 7 cycles: kl_q stays at 24576 (p=16384, d=65536 case) and iter does not advance.
  - m_tready held low 5 cycles: m_q_tdata, m_iter and m_tvalid are stable, and s_tready stays 0.
- Spurious kl_rsp_valid pulse during REQ is ignored: final q matches a clean run.
- Reset asserted while in WAIT at iter=5 -> all outputs 0 immediately. A new job then completes normally with results identical to a fresh run.
